// File: rtl/axi_slave_mem_pkg.sv
// axi_slave_mem_pkg: AXI response/burst codes, FSM encodings and helpers for axi_slave_mem.
package axi_slave_mem_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    // Response codes are ordered by severity, so the worst one is the larger code.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return a > b ? a : b;
    endfunction
    function automatic logic burst_bad(input logic [1:0] b);
        return b != AXI_BURST_FIXED && b != AXI_BURST_INCR;
    endfunction
endpackage

// File: rtl/axi_slave_mem_if.sv
// axi_slave_mem_if: AXI4 write/read channel bundle with master and slave views.
interface axi_slave_mem_if #(parameter int ID_WIDTH = 4) ();
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_slave_mem_bram.sv
// axi_slave_mem_bram: WORDS x 32 RAM, byte-enable write port and registered read port.
module axi_slave_mem_bram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    // Read samples the array before this edge's write lands: read-before-write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 subordinate over a byte-enable RAM, one burst in flight per direction.
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int          ID_WIDTH  = 4,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    axi_slave_mem_if.slave axi
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction
    function automatic logic [AW-1:0] word(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE_ADDR;
        return o[AW+1:2];
    endfunction
    logic unused_size;
    assign unused_size = ^{axi.awsize, axi.arsize};
    wr_state_t w_state, w_next;
    logic [ID_WIDTH-1:0] w_id;
    logic [31:0] w_addr;
    logic [7:0] w_len, w_cnt;
    logic [1:0] w_burst, w_resp, w_beat_resp;
    logic w_go, w_last, w_we;
    assign w_go = w_state == W_DATA && axi.wvalid;
    assign w_last = w_cnt == w_len;
    assign w_beat_resp = !in_range(w_addr) ? AXI_RESP_DECERR :
                         (burst_bad(w_burst) || axi.wlast != w_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign w_we = w_go && w_beat_resp == AXI_RESP_OKAY;
    always_comb begin
        w_next = (w_state == W_IDLE && axi.awvalid) ? W_DATA :
                 (w_go && w_last) ? W_RESP :
                 (w_state == W_RESP && axi.bready) ? W_IDLE : w_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= AXI_BURST_FIXED;
            w_resp  <= AXI_RESP_OKAY;
        end else if (w_state == W_IDLE && axi.awvalid) begin
            w_id    <= axi.awid;
            w_addr  <= axi.awaddr;
            w_len   <= axi.awlen;
            w_cnt   <= '0;
            w_burst <= axi.awburst;
            w_resp  <= AXI_RESP_OKAY;
        end else if (w_go) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= w_burst == AXI_BURST_INCR ? w_addr + 32'd4 : w_addr;
            w_resp <= resp_worst(w_resp, w_beat_resp);
        end
    end
    assign axi.awready = w_state == W_IDLE;
    assign axi.wready  = w_state == W_DATA;
    assign axi.bvalid  = w_state == W_RESP;
    assign axi.bid     = w_id;
    assign axi.bresp   = w_resp;
    rd_state_t r_state, r_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0] r_addr, l_addr, r_q;
    logic [7:0] r_len, r_cnt;
    logic [1:0] r_burst, r_resp, l_burst, l_resp;
    logic r_last, r_ok, r_start, r_adv, r_done;
    assign r_start = r_state == R_IDLE && axi.arvalid;
    assign r_adv   = r_state == R_DATA && axi.rready && !r_last;
    assign r_done  = r_state == R_DATA && axi.rready && r_last;
    // The beat being launched: beat 0 from AR, otherwise the successor of the presented beat.
    assign l_addr  = r_start ? axi.araddr : r_burst == AXI_BURST_INCR ? r_addr + 32'd4 : r_addr;
    assign l_burst = r_start ? axi.arburst : r_burst;
    assign l_resp  = !in_range(l_addr) ? AXI_RESP_DECERR :
                     burst_bad(l_burst) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    always_comb begin
        r_next = r_start ? R_DATA : r_done ? R_IDLE : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= AXI_BURST_FIXED;
            r_resp  <= AXI_RESP_OKAY;
            r_last  <= 1'b0;
            r_ok    <= 1'b0;
        end else if (r_start || r_adv) begin
            r_addr <= l_addr;
            r_resp <= l_resp;
            r_ok   <= l_resp == AXI_RESP_OKAY;
            r_cnt  <= r_start ? 8'd0 : r_cnt + 8'd1;
            r_last <= (r_start ? axi.arlen : r_len) == (r_start ? 8'd0 : r_cnt + 8'd1);
            if (r_start) begin
                r_id    <= axi.arid;
                r_len   <= axi.arlen;
                r_burst <= axi.arburst;
            end
        end else if (r_done) begin
            r_last <= 1'b0;
            r_ok   <= 1'b0;
        end
    end
    assign axi.arready = r_state == R_IDLE;
    assign axi.rvalid  = r_state == R_DATA;
    assign axi.rid     = r_id;
    assign axi.rresp   = r_resp;
    assign axi.rlast   = r_last;
    assign axi.rdata   = r_ok ? r_q : 32'd0;
    axi_slave_mem_bram #(.WORDS(MEM_WORDS)) u_bram (
        .clk   (clk),
        .we    (w_we),
        .be    (axi.wstrb),
        .waddr (word(w_addr)),
        .wdata (axi.wdata),
        .re    (r_start || r_adv),
        .raddr (word(l_addr)),
        .rdata (r_q)
    );
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed AXI traffic against axi_slave_mem with a read-beat scoreboard.
module tb_axi_slave_mem;
    import axi_slave_mem_pkg::*;
    localparam int MW = 1024;
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
    logic [31:0] model [int];
    rbeat_t exp_q [$];
    always #5 clk = ~clk;
    axi_slave_mem_if #(.ID_WIDTH(4)) axi ();
    axi_slave_mem #(.ID_WIDTH(4), .MEM_WORDS(MW), .BASE_ADDR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .axi (axi)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2; axi.awburst = burst; axi.awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (axi.awready) break;
            @(negedge clk);
        end
        chk("aw_ready", 32'(axi.awready), 1);
        @(posedge clk); #1 axi.awvalid = 1'b0;
    endtask
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd2; axi.arburst = burst; axi.arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (axi.arready) break;
            @(negedge clk);
        end
        chk("ar_ready", 32'(axi.arready), 1);
        @(posedge clk); #1 axi.arvalid = 1'b0;
    endtask
    task automatic send_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
        axi.wdata = d; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (axi.wready) break;
            @(negedge clk);
        end
        chk("w_ready", 32'(axi.wready), 1);
        @(posedge clk); #1 axi.wvalid = 1'b0;
    endtask
    task automatic b_resp(input logic [3:0] id, input logic [1:0] er, input int bwait);
        @(negedge clk);
        chk("b_valid", 32'(axi.bvalid), 1);
        chk("b_resp", 32'(axi.bresp), 32'(er));
        chk("b_id", 32'(axi.bid), 32'(id));
        for (int k = 0; k < bwait; k++) begin
            @(negedge clk);
            chk("b_hold_valid", 32'(axi.bvalid), 1);
            chk("b_hold_resp", 32'(axi.bresp), 32'(er));
            chk("b_hold_awready", 32'(axi.awready), 0);
        end
        axi.bready = 1'b1;
        @(posedge clk); #1 axi.bready = 1'b0;
        @(negedge clk);
        chk("b_done_valid", 32'(axi.bvalid), 0);
        chk("b_done_awready", 32'(axi.awready), 1);
    endtask
    // Beat i carries d0 + i*step; early >= 0 raises wlast on that beat as well as on the last.
    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [31:0] d0, input logic [31:0] step, input logic [3:0] strb, input int early, input int bwait);
        logic [1:0] er, br;
        logic [31:0] a, d, m;
        logic lst;
        er = AXI_RESP_OKAY;
        do_aw(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            a = burst == AXI_BURST_FIXED ? addr : addr + 32'(4 * i);
            d = d0 + step * 32'(i);
            lst = i == int'(len) || i == early;
            br = a >= 32'(4 * MW) ? AXI_RESP_DECERR :
                 (burst > AXI_BURST_INCR || lst != (i == int'(len))) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (br > er) er = br;
            if (br == AXI_RESP_OKAY) begin
                m = model.exists(int'(a >> 2)) ? model[int'(a >> 2)] : 32'hx;
                for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = d[8*b +: 8];
                model[int'(a >> 2)] = m;
            end
            send_beat(d, strb, lst);
            if (i < int'(len)) begin
                @(negedge clk);
                chk("b_early", 32'(axi.bvalid), 0);
            end
        end
        b_resp(id, er, bwait);
    endtask
    task automatic push_rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        rbeat_t e;
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = burst == AXI_BURST_FIXED ? addr : addr + 32'(4 * i);
            e.resp = a >= 32'(4 * MW) ? AXI_RESP_DECERR : burst > AXI_BURST_INCR ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            e.data = e.resp == AXI_RESP_OKAY ? model[int'(a >> 2)] : 32'd0;
            e.last = i == int'(len);
            e.id = id;
            exp_q.push_back(e);
        end
    endtask
    task automatic r_collect(input bit toggle);
        rbeat_t e;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            axi.rready = toggle ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            e = exp_q[0];
            chk("r_valid", 32'(axi.rvalid), 1);
            chk("r_data", axi.rdata, e.data);
            chk("r_resp", 32'(axi.rresp), 32'(e.resp));
            chk("r_last", 32'(axi.rlast), 32'(e.last));
            chk("r_id", 32'(axi.rid), 32'(e.id));
            if (axi.rready) void'(exp_q.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        chk("r_beats_left", 32'(exp_q.size()), 0);
        exp_q.delete();
        axi.rready = 1'b0;
        @(negedge clk);
        chk("r_end_valid", 32'(axi.rvalid), 0);
        chk("r_end_arready", 32'(axi.arready), 1);
    endtask
    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input bit toggle);
        push_rd(id, addr, len, burst);
        do_ar(id, addr, len, burst);
        r_collect(toggle);
    endtask
    initial begin
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(axi.awready), 1);
        chk("rst_arready", 32'(axi.arready), 1);
        chk("rst_wready", 32'(axi.wready), 0);
        chk("rst_bvalid", 32'(axi.bvalid), 0);
        chk("rst_rvalid", 32'(axi.rvalid), 0);
        chk("rst_rlast", 32'(axi.rlast), 0);
        chk("rst_bresp", 32'(axi.bresp), 0);
        chk("rst_rresp", 32'(axi.rresp), 0);
        chk("rst_bid", 32'(axi.bid), 0);
        chk("rst_rid", 32'(axi.rid), 0);
        chk("rst_rdata", axi.rdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        wr_burst(4'h3, 32'h10, 8'd0, AXI_BURST_INCR, 32'hDEADBEEF, 32'd0, 4'hF, -1, 0);
        rd_burst(4'h6, 32'h10, 8'd0, AXI_BURST_INCR, 1'b0);
        wr_burst(4'h1, 32'h0, 8'd4, AXI_BURST_INCR, 32'd1, 32'd1, 4'hF, -1, 0);
        rd_burst(4'h2, 32'h0, 8'd4, AXI_BURST_INCR, 1'b0);
        wr_burst(4'h0, 32'h200, 8'd0, AXI_BURST_INCR, 32'hFFFFFFFF, 32'd0, 4'hF, -1, 0);
        wr_burst(4'h0, 32'h200, 8'd0, AXI_BURST_INCR, 32'h00000000, 32'd0, 4'b0101, -1, 0);
        rd_burst(4'h9, 32'h200, 8'd0, AXI_BURST_INCR, 1'b0);
        wr_burst(4'h7, 32'h100, 8'd2, AXI_BURST_INCR, 32'h100, 32'h11, 4'hF, -1, 5);
        rd_burst(4'h8, 32'h100, 8'd2, AXI_BURST_INCR, 1'b1);
        wr_burst(4'h2, 32'h300, 8'd2, AXI_BURST_FIXED, 32'hA, 32'd1, 4'hF, -1, 0);
        rd_burst(4'h2, 32'h300, 8'd1, AXI_BURST_FIXED, 1'b1);
        // Error responses and RAM protection.
        wr_burst(4'h1, 32'(4 * MW), 8'd0, AXI_BURST_INCR, 32'h5555, 32'd0, 4'hF, -1, 0);
        rd_burst(4'h1, 32'(4 * MW), 8'd0, AXI_BURST_INCR, 1'b0);
        wr_burst(4'h1, 32'h10, 8'd1, AXI_BURST_WRAP, 32'h12345678, 32'd1, 4'hF, -1, 0);
        rd_burst(4'h1, 32'h10, 8'd0, AXI_BURST_INCR, 1'b0);
        wr_burst(4'h4, 32'h20, 8'd3, AXI_BURST_INCR, 32'h77, 32'd1, 4'hF, 1, 0);
        wr_burst(4'h1, 32'hFF8, 8'd1, AXI_BURST_INCR, 32'hE0, 32'd1, 4'hF, -1, 0);
        rd_burst(4'h5, 32'hFF8, 8'd3, AXI_BURST_INCR, 1'b1);
        wr_burst(4'h1, 32'hFFC, 8'd1, AXI_BURST_INCR, 32'hF0, 32'd1, 4'hF, -1, 0);
        rd_burst(4'hA, 32'h0, 8'd1, AXI_BURST_WRAP, 1'b0);
        // Same-word read and write on one edge: the read returns the old word.
        wr_burst(4'h3, 32'h40, 8'd0, AXI_BURST_INCR, 32'h11111111, 32'd0, 4'hF, -1, 0);
        push_rd(4'h3, 32'h40, 8'd0, AXI_BURST_INCR);
        do_aw(4'h2, 32'h40, 8'd0, AXI_BURST_INCR);
        axi.wdata = 32'h22222222; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
        axi.arid = 4'h3; axi.araddr = 32'h40; axi.arlen = 8'd0; axi.arburst = AXI_BURST_INCR; axi.arvalid = 1'b1;
        @(negedge clk);
        chk("same_wready", 32'(axi.wready), 1);
        chk("same_arready", 32'(axi.arready), 1);
        @(posedge clk); #1 axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        model[32'h40 >> 2] = 32'h22222222;
        r_collect(1'b0);
        b_resp(4'h2, AXI_RESP_OKAY, 0);
        rd_burst(4'h3, 32'h40, 8'd0, AXI_BURST_INCR, 1'b0);
        // Reset during beat 2 of a 4-beat write while a read beat is stalled.
        do_ar(4'h4, 32'h40, 8'd0, AXI_BURST_INCR);
        do_aw(4'h5, 32'h80, 8'd3, AXI_BURST_INCR);
        send_beat(32'hA0, 4'hF, 1'b0);
        send_beat(32'hA1, 4'hF, 1'b0);
        model[32'h80 >> 2] = 32'hA0;
        model[32'h84 >> 2] = 32'hA1;
        axi.wdata = 32'hA2; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        @(negedge clk);
        chk("pre_rst_rvalid", 32'(axi.rvalid), 1);
        chk("pre_rst_wready", 32'(axi.wready), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", 32'(axi.bvalid), 0);
        chk("mid_rst_rvalid", 32'(axi.rvalid), 0);
        chk("mid_rst_wready", 32'(axi.wready), 0);
        chk("mid_rst_awready", 32'(axi.awready), 1);
        chk("mid_rst_arready", 32'(axi.arready), 1);
        axi.wvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", 32'(axi.awready), 1);
        chk("post_rst_arready", 32'(axi.arready), 1);
        chk("post_rst_bvalid", 32'(axi.bvalid), 0);
        chk("post_rst_rvalid", 32'(axi.rvalid), 0);
        rd_burst(4'h6, 32'h80, 8'd1, AXI_BURST_INCR, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
